// File: rtl/sc64.sv
// Shared SoC package: bus master identifiers and the read data returned on a timed-out transaction.
package sc64;

  typedef enum bit [0:0] {M_CPU, M_AUX} e_cpu_bus_master;

  localparam logic [31:0] CPU_BUS_TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Request/ack pulse bus between two masters, the arbiter and the downstream decoder.
interface cpu_bus_arbiter_if;

  logic        m0_request;
  logic [31:0] m0_address;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_request;
  logic [31:0] m1_address;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic        s_request;
  logic [31:0] s_address;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_ack;
  logic [31:0] s_rdata;

  // Arbiter view: serves both masters and drives the downstream bus.
  modport slave (
    input  m0_request, m0_address, m0_wdata, m0_wmask,
    output m0_ack, m0_rdata,
    input  m1_request, m1_address, m1_wdata, m1_wmask,
    output m1_ack, m1_rdata,
    output s_request, s_address, s_wdata, s_wmask,
    input  s_ack, s_rdata
  );

  // Environment view: the two masters plus the downstream responder.
  modport master (
    output m0_request, m0_address, m0_wdata, m0_wmask,
    input  m0_ack, m0_rdata,
    output m1_request, m1_address, m1_wdata, m1_wmask,
    input  m1_ack, m1_rdata,
    input  s_request, s_address, s_wdata, s_wmask,
    output s_ack, s_rdata
  );

endinterface

// File: rtl/cpu_bus_watchdog.sv
// Busy-cycle counter; expire_o pulses in the TIMEOUT_CYCLES-th busy cycle after a clear.
module cpu_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic busy_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (busy_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = busy_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one pulse-handshake CPU bus between two masters, one transaction in flight.
// Optional busy timeout with sticky error flag under CPU_BUS_ARBITER_TIMEOUT_EN.
module cpu_bus_arbiter
  import sc64::*;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
  input  logic               clk,
  input  logic               reset,
  cpu_bus_arbiter_if.slave   bus,
  output logic               timeout_error
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_M0, S_BUSY_M1} e_arbiter_state;

  e_arbiter_state  state_q, state_d;
  logic            pend0_q, pend0_d;
  logic            pend1_q, pend1_d;
  e_cpu_bus_master last_grant_q, last_grant_d;
  logic            s_request_q, s_request_d;
  logic            grant_vld;
  e_cpu_bus_master grant_m;
  logic            busy;
  logic            expire;
  logic            done;

  assign busy = (state_q != S_IDLE);

`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
  logic timeout_error_q;

  cpu_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (grant_vld),
    .busy_i   (busy),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_error_q <= 1'b0;
    end else if (expire && !bus.s_ack) begin
      timeout_error_q <= 1'b1;
    end
  end

  assign timeout_error = timeout_error_q;
`else
  assign expire        = 1'b0;
  assign timeout_error = 1'b0;
`endif

  // A same-cycle s_ack always takes precedence over expiry.
  assign done = busy && (bus.s_ack || expire);

  always_comb begin
    state_d      = state_q;
    pend0_d      = pend0_q | bus.m0_request;
    pend1_d      = pend1_q | bus.m1_request;
    last_grant_d = last_grant_q;
    s_request_d  = 1'b0;
    grant_vld    = 1'b0;
    grant_m      = M_CPU;

    unique case (state_q)
      S_IDLE: begin
        if (pend0_d || pend1_d) begin
          grant_vld = 1'b1;
          if (pend0_d && pend1_d) begin
            grant_m = (last_grant_q == M_CPU) ? M_AUX : M_CPU;
          end else begin
            grant_m = pend0_d ? M_CPU : M_AUX;
          end
        end
        if (grant_vld) begin
          state_d      = (grant_m == M_CPU) ? S_BUSY_M0 : S_BUSY_M1;
          last_grant_d = grant_m;
          s_request_d  = 1'b1;
          if (grant_m == M_CPU) begin
            pend0_d = 1'b0;
          end else begin
            pend1_d = 1'b0;
          end
        end
      end
      S_BUSY_M0, S_BUSY_M1: begin
        if (done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      last_grant_q <= M_AUX;
      s_request_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      last_grant_q <= last_grant_d;
      s_request_q  <= s_request_d;
    end
  end

  assign bus.s_request = s_request_q;

  always_comb begin
    bus.s_address = '0;
    bus.s_wdata   = '0;
    bus.s_wmask   = '0;
    bus.m0_ack    = 1'b0;
    bus.m0_rdata  = '0;
    bus.m1_ack    = 1'b0;
    bus.m1_rdata  = '0;

    unique case (state_q)
      S_BUSY_M0: begin
        bus.s_address = bus.m0_address;
        bus.s_wdata   = bus.m0_wdata;
        bus.s_wmask   = bus.m0_wmask;
        bus.m0_ack    = done;
        if (done) begin
          bus.m0_rdata = bus.s_ack ? bus.s_rdata : CPU_BUS_TIMEOUT_RDATA;
        end
      end
      S_BUSY_M1: begin
        bus.s_address = bus.m1_address;
        bus.s_wdata   = bus.m1_wdata;
        bus.s_wmask   = bus.m1_wmask;
        bus.m1_ack    = done;
        if (done) begin
          bus.m1_rdata = bus.s_ack ? bus.s_rdata : CPU_BUS_TIMEOUT_RDATA;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
